// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs, ALU codes,
// datapath select values, FSM states and the store byte-lane helper.
package multicycle_control_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_J     = 6'h02;
    localparam logic [5:0] OPCODE_BEQ   = 6'h04;
    localparam logic [5:0] OPCODE_ADDI  = 6'h08;
    localparam logic [5:0] OPCODE_LW    = 6'h23;
    localparam logic [5:0] OPCODE_SB    = 6'h28;
    localparam logic [5:0] OPCODE_SH    = 6'h29;
    localparam logic [5:0] OPCODE_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [3:0] ALU_SLL = 4'h0;
    localparam logic [3:0] ALU_SRL = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h3;
    localparam logic [3:0] ALU_AND = 4'h4;
    localparam logic [3:0] ALU_OR  = 4'h5;
    localparam logic [3:0] ALU_SLT = 4'h6;

    localparam logic ALU_A_SEL_RS       = 1'b0;
    localparam logic ALU_A_SEL_SHAMT    = 1'b1;
    localparam logic ALU_B_SEL_RT       = 1'b0;
    localparam logic ALU_B_SEL_IMM      = 1'b1;
    localparam logic REG_D_ADDR_SEL_RT  = 1'b0;
    localparam logic REG_D_ADDR_SEL_RD  = 1'b1;
    localparam logic REG_D_DATA_SEL_ALU = 1'b0;
    localparam logic REG_D_DATA_SEL_MEM = 1'b1;
    localparam logic MEM_ADDR_SEL_PC    = 1'b0;
    localparam logic MEM_ADDR_SEL_ALU   = 1'b1;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
    } state_e;

    typedef struct packed {
        logic [3:0] we;
        logic       misaligned;
    } store_lane_t;

    // Lane mask assumes a little-endian 32-bit word; misaligned stores must never reach memory.
    function automatic store_lane_t storeLanes(input logic [5:0] opcode, input logic [1:0] addrLo);
        store_lane_t r;
        r.we         = 4'h0;
        r.misaligned = 1'b0;
        case (opcode)
            OPCODE_SW: begin
                r.we         = 4'hF;
                r.misaligned = (addrLo != 2'd0);
            end
            OPCODE_SH: begin
                r.we         = addrLo[1] ? 4'hC : 4'h3;
                r.misaligned = addrLo[0];
            end
            OPCODE_SB: r.we = 4'h1 << addrLo;
            default:   r.we = 4'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// R-type funct to ALU operation decoder, shared with the single-cycle control.
// valid_o low flags a funct this datapath cannot execute.
module alu_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       alu_a_sel_o,
    output logic       valid_o
);

    always_comb begin
        alu_op_o    = ALU_SLL;
        alu_a_sel_o = ALU_A_SEL_RS;
        valid_o     = 1'b1;
        case (funct_i)
            FUNCT_SLL: alu_a_sel_o = ALU_A_SEL_SHAMT;
            FUNCT_SRL: begin
                alu_op_o    = ALU_SRL;
                alu_a_sel_o = ALU_A_SEL_SHAMT;
            end
            FUNCT_ADD: alu_op_o = ALU_ADD;
            FUNCT_SUB: alu_op_o = ALU_SUB;
            FUNCT_AND: alu_op_o = ALU_AND;
            FUNCT_OR:  alu_op_o = ALU_OR;
            FUNCT_SLT: alu_op_o = ALU_SLT;
            default:   valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a shared memory
// port with ready handshake, optional memory timeout and a sticky trap state.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit          ENABLE_SUBWORD = 1'b1,
    parameter bit          ENABLE_JUMP    = 1'b1,
    parameter int unsigned MEM_TIMEOUT    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       reg_s_t_equal_i,
    input  logic [1:0] addr_lo_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_addr_sel_o,
    output logic [3:0] mem_we_o,
    output logic       ir_we_o,
    output logic [3:0] alu_op_o,
    output logic       alu_a_sel_o,
    output logic       alu_b_sel_o,
    output logic       pc_we_o,
    output logic [1:0] pc_src_o,
    output logic       reg_d_we_o,
    output logic       reg_d_addr_sel_o,
    output logic       reg_d_data_sel_o,
    output logic       trap_o
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] waitCnt_q, waitCnt_d;
    logic [3:0]  rAluOp;
    logic        rAluASel;
    logic        rValid;
    logic        memWaiting;
    logic        timeoutHit;
    store_lane_t lanes;

    alu_decode u_alu_decode (
        .funct_i    (funct_i),
        .alu_op_o   (rAluOp),
        .alu_a_sel_o(rAluASel),
        .valid_o    (rValid)
    );

    assign lanes      = storeLanes(opcode_i, addr_lo_i);
    assign memWaiting = mem_req_o && !mem_ready_i;
    // Limit is hit on the cycle the count would reach MEM_TIMEOUT, so ready that cycle still wins.
    assign timeoutHit = (MEM_TIMEOUT != 0) && memWaiting && (waitCnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            waitCnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i)     state_d = S_DECODE;
                else if (timeoutHit) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (opcode_i)
                    OPCODE_RTYPE:         state_d = rValid ? S_EXEC_R : S_TRAP;
                    OPCODE_ADDI:          state_d = S_EXEC_I;
                    OPCODE_LW, OPCODE_SW: state_d = S_MEM_ADDR;
                    OPCODE_SB, OPCODE_SH: state_d = ENABLE_SUBWORD ? S_MEM_ADDR : S_TRAP;
                    OPCODE_BEQ:           state_d = S_BRANCH;
                    OPCODE_J:             state_d = ENABLE_JUMP ? S_JUMP : S_TRAP;
                    default:              state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I:  state_d = S_WB_ALU;
            S_WB_ALU, S_WB_MEM:  state_d = S_FETCH;
            S_MEM_ADDR:          state_d = (opcode_i == OPCODE_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready_i)     state_d = S_WB_MEM;
                else if (timeoutHit) state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (lanes.misaligned) state_d = S_TRAP;
                else if (mem_ready_i) state_d = S_FETCH;
                else if (timeoutHit)  state_d = S_TRAP;
            end
            S_BRANCH, S_JUMP:    state_d = S_FETCH;
            S_TRAP:              state_d = S_TRAP;
            default:             state_d = S_TRAP;
        endcase

        if (state_d != state_q)
            waitCnt_d = 16'd0;
        else if (memWaiting && (MEM_TIMEOUT != 0))
            waitCnt_d = waitCnt_q + 16'd1;
        else
            waitCnt_d = waitCnt_q;
    end

    always_comb begin
        mem_req_o        = 1'b0;
        mem_addr_sel_o   = MEM_ADDR_SEL_PC;
        mem_we_o         = 4'h0;
        ir_we_o          = 1'b0;
        alu_op_o         = ALU_SLL;
        alu_a_sel_o      = ALU_A_SEL_RS;
        alu_b_sel_o      = ALU_B_SEL_RT;
        pc_we_o          = 1'b0;
        pc_src_o         = PC_SRC_SEQ;
        reg_d_we_o       = 1'b0;
        reg_d_addr_sel_o = REG_D_ADDR_SEL_RT;
        reg_d_data_sel_o = REG_D_DATA_SEL_ALU;
        trap_o           = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o = 1'b1;
                alu_op_o  = ALU_ADD;
                ir_we_o   = mem_ready_i;
                pc_we_o   = mem_ready_i;
            end
            S_EXEC_R: begin
                alu_op_o         = rAluOp;
                alu_a_sel_o      = rAluASel;
                reg_d_addr_sel_o = REG_D_ADDR_SEL_RD;
            end
            S_EXEC_I: begin
                alu_op_o    = ALU_ADD;
                alu_b_sel_o = ALU_B_SEL_IMM;
            end
            S_WB_ALU: begin
                reg_d_we_o = 1'b1;
                if (opcode_i == OPCODE_RTYPE) begin
                    alu_op_o         = rAluOp;
                    alu_a_sel_o      = rAluASel;
                    reg_d_addr_sel_o = REG_D_ADDR_SEL_RD;
                end else begin
                    alu_op_o    = ALU_ADD;
                    alu_b_sel_o = ALU_B_SEL_IMM;
                end
            end
            S_MEM_ADDR: begin
                alu_op_o    = ALU_ADD;
                alu_b_sel_o = ALU_B_SEL_IMM;
            end
            S_MEM_RD: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = MEM_ADDR_SEL_ALU;
                alu_op_o       = ALU_ADD;
                alu_b_sel_o    = ALU_B_SEL_IMM;
            end
            S_MEM_WR: begin
                mem_req_o      = !lanes.misaligned;
                mem_we_o       = lanes.misaligned ? 4'h0 : lanes.we;
                mem_addr_sel_o = MEM_ADDR_SEL_ALU;
                alu_op_o       = ALU_ADD;
                alu_b_sel_o    = ALU_B_SEL_IMM;
            end
            S_WB_MEM: begin
                reg_d_we_o       = 1'b1;
                reg_d_data_sel_o = REG_D_DATA_SEL_MEM;
            end
            S_BRANCH: begin
                alu_op_o    = ALU_ADD;
                alu_b_sel_o = ALU_B_SEL_IMM;
                pc_src_o    = PC_SRC_BRANCH;
                pc_we_o     = reg_s_t_equal_i;
            end
            S_JUMP: begin
                pc_src_o = PC_SRC_JUMP;
                pc_we_o  = 1'b1;
            end
            S_TRAP:  trap_o = 1'b1;
            default: trap_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a default instance plus one with J and sub-word
// stores disabled and a 4-cycle memory timeout, driven from the same instruction stream.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       regEq, memReady;
    logic [1:0] addrLo;

    logic       memReq, memAddrSel, irWe, aluASel, aluBSel, pcWe, regDWe, regDAddrSel, regDDataSel, trap;
    logic [3:0] memWe, aluOp;
    logic [1:0] pcSrc;
    logic       memReqB, memAddrSelB, irWeB, aluASelB, aluBSelB, pcWeB, regDWeB, regDAddrSelB, regDDataSelB, trapB;
    logic [3:0] memWeB, aluOpB;
    logic [1:0] pcSrcB;
    logic [19:0] allA, allB;

    int checks = 0;
    int errors = 0;

    assign allA = {memReq, memAddrSel, memWe, irWe, aluOp, aluASel, aluBSel, pcWe, pcSrc,
                   regDWe, regDAddrSel, regDDataSel, trap};
    assign allB = {memReqB, memAddrSelB, memWeB, irWeB, aluOpB, aluASelB, aluBSelB, pcWeB, pcSrcB,
                   regDWeB, regDAddrSelB, regDDataSelB, trapB};

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct_i(funct),
        .reg_s_t_equal_i(regEq), .addr_lo_i(addrLo), .mem_ready_i(memReady),
        .mem_req_o(memReq), .mem_addr_sel_o(memAddrSel), .mem_we_o(memWe), .ir_we_o(irWe),
        .alu_op_o(aluOp), .alu_a_sel_o(aluASel), .alu_b_sel_o(aluBSel), .pc_we_o(pcWe),
        .pc_src_o(pcSrc), .reg_d_we_o(regDWe), .reg_d_addr_sel_o(regDAddrSel),
        .reg_d_data_sel_o(regDDataSel), .trap_o(trap)
    );

    multicycle_control #(.ENABLE_SUBWORD(1'b0), .ENABLE_JUMP(1'b0), .MEM_TIMEOUT(4)) dutB (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct_i(funct),
        .reg_s_t_equal_i(regEq), .addr_lo_i(addrLo), .mem_ready_i(memReady),
        .mem_req_o(memReqB), .mem_addr_sel_o(memAddrSelB), .mem_we_o(memWeB), .ir_we_o(irWeB),
        .alu_op_o(aluOpB), .alu_a_sel_o(aluASelB), .alu_b_sel_o(aluBSelB), .pc_we_o(pcWeB),
        .pc_src_o(pcSrcB), .reg_d_we_o(regDWeB), .reg_d_addr_sel_o(regDAddrSelB),
        .reg_d_data_sel_o(regDDataSelB), .trap_o(trapB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                                 input logic [1:0] lo, input logic rdy);
        opcode   = op;
        funct    = fn;
        regEq    = eq;
        addrLo   = lo;
        memReady = rdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves both DUTs one cycle into FETCH, sampled mid-cycle.
    task automatic resetDuts();
        rst_n = 1'b0;
        applyStimulus(OPCODE_RTYPE, FUNCT_ADD, 1'b0, 2'd0, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("reset_all_a", allA, 0);
        checkOutput("reset_all_b", allB, 0);
        rst_n = 1'b1;
        nextCycle();
    endtask

    // FETCH with ready, then DECODE; leaves the FSM in the first post-decode state.
    task automatic fetchInstr(input logic [5:0] op, input logic [5:0] fn, input string tag);
        opcode   = op;
        funct    = fn;
        memReady = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_fetch_irwe"}, irWe, 1);
        nextCycle();
        @(negedge clk);
        checkOutput({tag, "_decode_memreq"}, memReq, 0);
        nextCycle();
    endtask

    task automatic doStore(input logic [5:0] op, input logic [1:0] lo, input logic [3:0] expWe,
                           input string tag);
        fetchInstr(op, FUNCT_ADD, tag);
        addrLo = lo;
        @(negedge clk);
        checkOutput({tag, "_addr_alu"}, aluOp, ALU_ADD);
        nextCycle();
        @(negedge clk);
        checkOutput({tag, "_we"}, memWe, expWe);
        checkOutput({tag, "_req"}, memReq, 1);
        nextCycle();
    endtask

    task automatic doBranch(input logic eq, input string tag);
        fetchInstr(OPCODE_BEQ, FUNCT_ADD, tag);
        regEq = eq;
        @(negedge clk);
        checkOutput({tag, "_pcwe"}, pcWe, eq);
        checkOutput({tag, "_pcsrc"}, pcSrc, PC_SRC_BRANCH);
        nextCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // ADD from reset: WB_ALU lands in cycle 4
        resetDuts();
        fetchInstr(OPCODE_RTYPE, FUNCT_ADD, "add");
        @(negedge clk);
        checkOutput("add_exec_aluop", aluOp, ALU_ADD);
        checkOutput("add_exec_rd", regDAddrSel, REG_D_ADDR_SEL_RD);
        checkOutput("add_exec_regwe", regDWe, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("add_wb_regwe", regDWe, 1);
        checkOutput("add_wb_datasel", regDDataSel, REG_D_DATA_SEL_ALU);
        nextCycle();

        // LW with three wait cycles in MEM_RD, WB_MEM in cycle 8
        fetchInstr(OPCODE_LW, FUNCT_ADD, "lw");
        @(negedge clk);
        checkOutput("lw_addr_bsel", aluBSel, ALU_B_SEL_IMM);
        nextCycle();
        memReady = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("lw_wait%0d_req", c), memReq, 1);
            checkOutput($sformatf("lw_wait%0d_addrsel", c), memAddrSel, MEM_ADDR_SEL_ALU);
            checkOutput($sformatf("lw_wait%0d_regwe", c), regDWe, 0);
            nextCycle();
        end
        memReady = 1'b1;
        @(negedge clk);
        checkOutput("lw_c7_req", memReq, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("lw_c8_regwe", regDWe, 1);
        checkOutput("lw_c8_datasel", regDDataSel, REG_D_DATA_SEL_MEM);
        nextCycle();

        // ADDI writes back to rt with immediate operand
        fetchInstr(OPCODE_ADDI, FUNCT_ADD, "addi");
        @(negedge clk);
        checkOutput("addi_exec_bsel", aluBSel, ALU_B_SEL_IMM);
        nextCycle();
        @(negedge clk);
        checkOutput("addi_wb_rt", {regDWe, regDAddrSel}, 2'b10);
        nextCycle();

        // Byte-lane stores; dutB has sub-word disabled and traps on SB
        doStore(OPCODE_SB, 2'd2, 4'b0100, "sb2");
        checkOutput("sb_disabled_trap_b", trapB, 1);
        doStore(OPCODE_SH, 2'd2, 4'b1100, "sh2");
        doStore(OPCODE_SH, 2'd0, 4'b0011, "sh0");
        doStore(OPCODE_SW, 2'd0, 4'b1111, "sw0");

        doBranch(1'b0, "beq0");
        doBranch(1'b1, "beq1");

        fetchInstr(OPCODE_J, FUNCT_ADD, "j");
        @(negedge clk);
        checkOutput("j_pc", {pcWe, pcSrc}, {1'b1, PC_SRC_JUMP});
        nextCycle();

        // Misaligned SH: no write, then sticky trap
        fetchInstr(OPCODE_SH, FUNCT_ADD, "sh1");
        addrLo = 2'd1;
        nextCycle();
        @(negedge clk);
        checkOutput("sh1_wr_we", memWe, 4'h0);
        checkOutput("sh1_wr_req", memReq, 0);
        nextCycle();
        repeat (2) begin
            @(negedge clk);
            checkOutput("sh1_trap", {trap, memWe, memReq}, 6'b100000);
            nextCycle();
        end

        // Illegal opcode 0x3F: sticky trap even with memory ready
        resetDuts();
        fetchInstr(6'h3F, FUNCT_ADD, "ill");
        repeat (3) begin
            @(negedge clk);
            checkOutput("ill_trap", {trap, memReq, irWe}, 3'b100);
            nextCycle();
        end

        // J with jump disabled on dutB
        resetDuts();
        fetchInstr(OPCODE_J, FUNCT_ADD, "jdis");
        @(negedge clk);
        checkOutput("jdis_trap_b", trapB, 1);
        checkOutput("jdis_pcwe_b", pcWeB, 0);
        checkOutput("jdis_pcwe_a", pcWe, 1);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("jdis_sticky_b", trapB, 1);

        // Timeout: four unanswered FETCH cycles trap dutB only
        resetDuts();
        memReady = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("to_c%0d_trap_b", c), trapB, 0);
            checkOutput($sformatf("to_c%0d_req_b", c), memReqB, 1);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("to_trap_b", {trapB, memReqB}, 2'b10);
        checkOutput("to_wait_a", {trap, memReq}, 2'b01);

        // Ready on the fourth wait cycle beats the limit
        resetDuts();
        memReady = 1'b0;
        repeat (3) nextCycle();
        memReady = 1'b1;
        @(negedge clk);
        checkOutput("to_ready_irwe_b", irWeB, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("to_ready_notrap_b", trapB, 0);

        // Asynchronous reset mid-FETCH drops mem_req immediately
        resetDuts();
        memReady = 1'b0;
        @(negedge clk);
        checkOutput("midrst_req_before", memReq, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_all_a", allA, 0);
        checkOutput("midrst_all_b", allB, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("midrst_refetch", memReq, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
